actuator_resp: RTL and testbench
================================

ACTUATOR_RESP -- requirements
Module: actuator_resp

Interface
REQ-001 The block SHALL be parameterised by MAX_POS, default 9, the top position limit (4-bit range, 1..15).
REQ-002 The block SHALL be parameterised by STEP_CYCLES, default 4, the clock cycles per position step (1..255).
REQ-003 The block SHALL be parameterised by DEAD_CYCLES, default 2, the reversal dead-time in cycles (1..15).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with the clock and reset ports named as the codebase does.
REQ-005 inputClk  in  1  the single clock; all state changes on its rising edge.
REQ-006 inputReset  in  1  asynchronous active-high reset.
REQ-007 inputB0, inputB1  in  1 each  command from the controller, {B1,B0}: 00 HOLD, 01 UP, 10 DOWN, 11 HOME; synchronous to inputClk.
REQ-008 inputReq  in  1  asynchronous user request line.
REQ-009 outputI  out  1  latched request to the controller.
REQ-010 outputS  out  1  limit/done status to the controller.
REQ-011 outputPos  out  4  current position.
REQ-012 outputBusy  out  1  high while in MOVE_UP, MOVE_DOWN, HOMING or DEAD.

Function
REQ-013 The FSM SHALL have the states IDLE, MOVE_UP, MOVE_DOWN, HOMING and DEAD, registered and Moore-style; every output is a function of registered state only.
REQ-014 IDLE SHALL go to MOVE_UP on 01, to MOVE_DOWN on 10, to HOMING on 11, and stay in IDLE on 00.
REQ-015 Any move state SHALL return to IDLE on 00, and HOMING-to-UP or HOMING-to-DOWN SHALL switch directly.
REQ-016 On state entry the step timer SHALL load STEP_CYCLES-1; when it reaches 0, outputPos steps by ±1 (HOMING counts as down) and the timer reloads, so the first step comes STEP_CYCLES cycles after entry.
REQ-017 Position SHALL saturate: no increment at MAX_POS, no decrement at 0; the timer keeps running and no wrap-around is allowed.
REQ-018 outputS SHALL be high when (MOVE_UP and pos==MAX_POS) or ((MOVE_DOWN or HOMING) and pos==0); otherwise it is low.
REQ-019 outputS SHALL rise in the same edge as the limit-reaching step.
REQ-020 inputReq SHALL pass through a 2-flop synchroniser and a rising-edge detector; a detected edge sets outputI.
REQ-021 outputI SHALL clear on any cycle whose sampled command is not 00; if set and clear occur in the same cycle, set wins.
REQ-022 A held command SHALL re-enter no state; the timer reloads only on a state change.

Reset
REQ-023 Asserting inputReset SHALL immediately force IDLE, outputPos=0, outputI=0, outputS=0, outputBusy=0, timer=0, synchroniser and edge flops=0.
REQ-024 Asserting inputReset mid-move SHALL abort the move, and after deassertion the block SHALL wait in IDLE for the next command edge.

Configuration
REQ-025 With REVERSE_DEADTIME_EN defined, a direct UP<->DOWN command change SHALL enter DEAD for DEAD_CYCLES cycles (position frozen, outputS=0, outputBusy=1) and then take the currently sampled command from IDLE rules.
REQ-026 With REVERSE_DEADTIME_EN defined, a reset SHALL abort DEAD.
REQ-027 Without REVERSE_DEADTIME_EN, DEAD and its counter SHALL not exist, and a reversal SHALL switch states directly with a timer reload.

Structure
REQ-028 The shared package control_pkg SHALL hold the command encodings (CMD_HOLD, CMD_UP, CMD_DOWN, CMD_HOME) and the state enumeration typedef, both reused by the controller FSM.
REQ-029 One sub-module, step_timer, SHALL implement the loadable down-counter with a zero flag; the FSM, the position register and the request latch stay in actuator_resp.

Verification
REQ-030 Reset, then cmd 01 held with STEP_CYCLES=4 -> pos goes 1 at cycle 4 and 2 at cycle 8, and reaches 9 at cycle 36 with S=1 there; pos holds at 9 afterwards.
REQ-031 pos=3, then cmd 11 -> pos steps to 0 every 4 cycles, S=1 at the 0-step and stays 1 while 11 is held; cmd 00 -> S=0, Busy=0.
REQ-032 inputReq rising edge while cmd=00 -> outputI=1 three cycles later; then cmd 01 -> outputI=0 next edge; req edge and non-00 cmd in the same cycle -> outputI=1.
REQ-033 With REVERSE_DEADTIME_EN and DEAD_CYCLES=2, pos=5 in MOVE_UP, then cmd 10 -> 2 DEAD cycles with pos=5 and Busy=1, then MOVE_DOWN, first decrement 4 cycles later; without the macro -> MOVE_DOWN immediately.
REQ-034 Reset asserted at pos=6 mid-step -> outputs all 0 asynchronously, and after release with cmd 00 the block stays in IDLE.
REQ-035 Cmd 10 at pos=0 -> S=1 one cycle after entry... at first step edge (cycle 4), pos stays 0, no underflow.

Source files
------------

// File: rtl/control_pkg.sv
// Shared controller definitions: command encodings, FSM state type, command decode.
// Latency: n/a (package, no logic of its own).
// Backpressure: n/a.
//
// Items: CMD_HOLD/CMD_UP/CMD_DOWN/CMD_HOME, ctrlStateT, cmdToState(), isReversal().
// Optional feature macro: REVERSE_DEADTIME_EN adds the DEAD state to ctrlStateT.
package control_pkg;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DOWN = 2'b10;
  localparam logic [1:0] CMD_HOME = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    HOMING    = 3'd3
`ifdef REVERSE_DEADTIME_EN
    ,
    DEAD      = 3'd4
`endif
  } ctrlStateT;

  // Target state for a command as seen from IDLE; move states use the same map.
  function automatic ctrlStateT cmdToState(input logic [1:0] cmd);
    cmdToState = IDLE;
    case (cmd)
      CMD_UP:   cmdToState = MOVE_UP;
      CMD_DOWN: cmdToState = MOVE_DOWN;
      CMD_HOME: cmdToState = HOMING;
      default:  cmdToState = IDLE;
    endcase
  endfunction

  // Direct UP<->DOWN change; HOMING transitions are never treated as reversals.
  function automatic logic isReversal(input ctrlStateT cur, input logic [1:0] cmd);
    isReversal = ((cur == MOVE_UP) && (cmd == CMD_DOWN)) ||
                 ((cur == MOVE_DOWN) && (cmd == CMD_UP));
  endfunction

endpackage

// File: rtl/actuator_resp_step_timer.sv
// Loadable down-counter that stops at zero and flags it.
// Latency: load visible one cycle after the load edge; zero flag is combinational from the count register.
// Backpressure: none; counts every cycle while non-zero.
//
// Ports: inputClk, inputReset (async active-high), load, loadValue[WIDTH], zero.
module step_timer #(
  parameter int WIDTH = 8
) (
  input  logic             inputClk,
  input  logic             inputReset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge inputClk or posedge inputReset) begin
    if (inputReset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/actuator_resp.sv
// Stepper-style actuator responder: command FSM, saturating position, limit status, latched user request.
// Latency: state/outputs register on the command sampling edge; first step STEP_CYCLES cycles after entry; request shows 3 cycles after its rising edge.
// Backpressure: none; a new command is accepted every cycle.
//
// Ports: inputClk, inputReset (async active-high), inputB0/inputB1 command {B1,B0}, inputReq (async),
//        outputI request latch, outputS limit status, outputPos[3:0], outputBusy.
// Optional feature macro: REVERSE_DEADTIME_EN inserts a DEAD_CYCLES dead-time on UP<->DOWN reversal.
module actuator_resp
  import control_pkg::*;
#(
  parameter int MAX_POS     = 9,
  parameter int STEP_CYCLES = 4,
  parameter int DEAD_CYCLES = 2
) (
  input  logic       inputClk,
  input  logic       inputReset,
  input  logic       inputB0,
  input  logic       inputB1,
  input  logic       inputReq,
  output logic       outputI,
  output logic       outputS,
  output logic [3:0] outputPos,
  output logic       outputBusy
);

  if (MAX_POS < 1 || MAX_POS > 15 || STEP_CYCLES < 1 || STEP_CYCLES > 255 ||
      DEAD_CYCLES < 1 || DEAD_CYCLES > 15) begin : gParamCheck
    $error("actuator_resp: parameter out of range");
  end

  localparam logic [3:0] MaxPos   = 4'(MAX_POS);
  localparam logic [7:0] StepLoad = 8'(STEP_CYCLES - 1);

  logic [1:0] cmd;
  ctrlStateT  state;
  ctrlStateT  nextState;
  logic [3:0] nextPos;
  logic       nextS;
  logic       stateChange;
  logic       moving;
  logic       timerLoad;
  logic       timerZero;
  logic       reqMeta;
  logic       reqSync;
  logic       reqPrev;
  logic       reqEdge;

`ifdef REVERSE_DEADTIME_EN
  localparam logic [3:0] DeadLoad = 4'(DEAD_CYCLES - 1);
  logic [3:0] deadCnt;
`endif

  assign cmd         = {inputB1, inputB0};
  assign moving      = state inside {MOVE_UP, MOVE_DOWN, HOMING};
  assign stateChange = (nextState != state);
  // Reload on any state entry, and on every step boundary while moving.
  assign timerLoad   = stateChange | (timerZero & moving);
  assign reqEdge     = reqSync & ~reqPrev;

  step_timer #(.WIDTH(8)) uStepTimer (
    .inputClk  (inputClk),
    .inputReset(inputReset),
    .load      (timerLoad),
    .loadValue (StepLoad),
    .zero      (timerZero)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE, MOVE_UP, MOVE_DOWN, HOMING: nextState = cmdToState(cmd);
`ifdef REVERSE_DEADTIME_EN
      // Dead-time over: the command sampled now is decoded as if from IDLE.
      DEAD: if (deadCnt == 4'd0) nextState = cmdToState(cmd);
`endif
      default: nextState = IDLE;
    endcase
`ifdef REVERSE_DEADTIME_EN
    if (isReversal(state, cmd)) nextState = DEAD;
`endif
  end

  // Steps only happen while the state is held; an entry edge never steps.
  always_comb begin
    nextPos = outputPos;
    if (!stateChange && timerZero) begin
      if (state == MOVE_UP) begin
        if (outputPos != MaxPos) nextPos = outputPos + 4'd1;
      end else if (state == MOVE_DOWN || state == HOMING) begin
        if (outputPos != 4'd0) nextPos = outputPos - 4'd1;
      end
    end
    // Computed from next values so status rises on the limit-reaching edge.
    nextS = ((nextState == MOVE_UP) && (nextPos == MaxPos)) ||
            (((nextState == MOVE_DOWN) || (nextState == HOMING)) && (nextPos == 4'd0));
  end

  always_ff @(posedge inputClk or posedge inputReset) begin
    if (inputReset) begin
      state      <= IDLE;
      outputPos  <= 4'd0;
      outputS    <= 1'b0;
      outputBusy <= 1'b0;
      outputI    <= 1'b0;
      reqMeta    <= 1'b0;
      reqSync    <= 1'b0;
      reqPrev    <= 1'b0;
`ifdef REVERSE_DEADTIME_EN
      deadCnt    <= 4'd0;
`endif
    end else begin
      state      <= nextState;
      outputPos  <= nextPos;
      outputS    <= nextS;
      outputBusy <= (nextState != IDLE);
      reqMeta    <= inputReq;
      reqSync    <= reqMeta;
      reqPrev    <= reqSync;
      // Set has priority over the non-HOLD clear.
      if (reqEdge) begin
        outputI <= 1'b1;
      end else if (cmd != CMD_HOLD) begin
        outputI <= 1'b0;
      end
`ifdef REVERSE_DEADTIME_EN
      if (nextState == DEAD && state != DEAD) begin
        deadCnt <= DeadLoad;
      end else if (deadCnt != 4'd0) begin
        deadCnt <= deadCnt - 4'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_actuator_resp.sv
// Self-checking bench for actuator_resp: directed scenarios plus randomized commands against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_actuator_resp;

  localparam int MAX_POS     = 9;
  localparam int STEP_CYCLES = 4;
  localparam int DEAD_CYCLES = 2;
`ifdef REVERSE_DEADTIME_EN
  localparam int LAG = DEAD_CYCLES;
`else
  localparam int LAG = 0;
`endif

  logic       inputClk = 1'b0;
  logic       inputReset = 1'b1;
  logic       inputB0 = 1'b0;
  logic       inputB1 = 1'b0;
  logic       inputReq = 1'b0;
  logic       outputI;
  logic       outputS;
  logic [3:0] outputPos;
  logic       outputBusy;

  int tests = 0;
  int failures = 0;

  // Reference model: 0 idle, 1 up, 2 down, 3 homing, 4 dead-time.
  int mState, mPos, mElapsed, mDeadLeft;
  bit mI, h1, h2, h3;

  actuator_resp #(.MAX_POS(MAX_POS), .STEP_CYCLES(STEP_CYCLES), .DEAD_CYCLES(DEAD_CYCLES)) dut (
    .inputClk  (inputClk),
    .inputReset(inputReset),
    .inputB0   (inputB0),
    .inputB1   (inputB1),
    .inputReq  (inputReq),
    .outputI   (outputI),
    .outputS   (outputS),
    .outputPos (outputPos),
    .outputBusy(outputBusy)
  );

  always #5 inputClk = ~inputClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit expS();
    return (mState == 1 && mPos == MAX_POS) || ((mState == 2 || mState == 3) && mPos == 0);
  endfunction

  task automatic modelReset();
    mState = 0; mPos = 0; mElapsed = 0; mDeadLeft = 0;
    mI = 0; h1 = 0; h2 = 0; h3 = 0;
  endtask

  // One clock edge with command c and request level q as sampled at that edge.
  task automatic modelEdge(input logic [1:0] c, input bit q);
    bit setI;
    int tgt, ns;
    // Request reaches the edge detector two edges after it is sampled.
    setI = h2 && !h3;
    h3 = h2; h2 = h1; h1 = q;
    if (setI) mI = 1;
    else if (c != 2'b00) mI = 0;
    tgt = int'(c);
    if (mState == 4) begin
      mDeadLeft--;
      ns = (mDeadLeft == 0) ? tgt : 4;
    end else begin
      ns = tgt;
`ifdef REVERSE_DEADTIME_EN
      if ((mState == 1 && tgt == 2) || (mState == 2 && tgt == 1)) begin
        ns = 4;
        mDeadLeft = DEAD_CYCLES;
      end
`endif
    end
    if (ns != mState) begin
      mState = ns;
      mElapsed = 0;
    end else if (mState >= 1 && mState <= 3) begin
      mElapsed++;
      if (mElapsed % STEP_CYCLES == 0) begin
        if (mState == 1) begin
          if (mPos < MAX_POS) mPos++;
        end else if (mPos > 0) begin
          mPos--;
        end
      end
    end
  endtask

  task automatic tick(input logic [1:0] c, input bit q);
    inputB1 = c[1]; inputB0 = c[0]; inputReq = q;
    @(posedge inputClk);
    modelEdge(c, q);
    #1;
  endtask

  task automatic doReset();
    inputReset = 1'b1;
    inputB1 = 1'b0; inputB0 = 1'b0; inputReq = 1'b0;
    modelReset();
    @(negedge inputClk);
    @(negedge inputClk);
    inputReset = 1'b0;
  endtask

  task automatic test_reset();
    modelReset();
    #1;
    tests++; if (outputPos !== 4'd0) begin failures++; $display("FAIL reset_pos: got %0d want 0", outputPos); end
    tests++; if (outputI !== 1'b0) begin failures++; $display("FAIL reset_I: got %b want 0", outputI); end
    tests++; if (outputS !== 1'b0) begin failures++; $display("FAIL reset_S: got %b want 0", outputS); end
    tests++; if (outputBusy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", outputBusy); end
    @(negedge inputClk);
    inputReset = 1'b0;
    for (int i = 0; i < 3; i++) tick(2'b00, 0);
    tests++; if (outputBusy !== 1'b0 || outputPos !== 4'd0) begin
      failures++; $display("FAIL reset_idle_hold: busy %b pos %0d want 0 0", outputBusy, outputPos);
    end
  endtask

  task automatic test_up_to_limit();
    tick(2'b01, 0);
    tests++; if (outputBusy !== 1'b1 || outputPos !== 4'd0) begin
      failures++; $display("FAIL up_entry: busy %b pos %0d want 1 0", outputBusy, outputPos);
    end
    for (int i = 1; i <= 40; i++) begin
      tick(2'b01, 0);
      if (i == 3) begin tests++; if (outputPos !== 4'd0) begin failures++; $display("FAIL up_c3_pos: got %0d want 0", outputPos); end end
      if (i == 4) begin tests++; if (outputPos !== 4'd1) begin failures++; $display("FAIL up_c4_pos: got %0d want 1", outputPos); end end
      if (i == 8) begin tests++; if (outputPos !== 4'd2) begin failures++; $display("FAIL up_c8_pos: got %0d want 2", outputPos); end end
      if (i == 35) begin tests++; if (outputPos !== 4'd8 || outputS !== 1'b0) begin
        failures++; $display("FAIL up_c35: pos %0d S %b want 8 0", outputPos, outputS); end end
      if (i == 36) begin tests++; if (outputPos !== 4'd9 || outputS !== 1'b1) begin
        failures++; $display("FAIL up_c36: pos %0d S %b want 9 1", outputPos, outputS); end end
      if (i == 40) begin tests++; if (outputPos !== 4'd9 || outputS !== 1'b1 || outputBusy !== 1'b1) begin
        failures++; $display("FAIL up_sat: pos %0d S %b busy %b want 9 1 1", outputPos, outputS, outputBusy); end end
    end
  endtask

  task automatic test_homing();
    int n;
    tick(2'b00, 0);
    tests++; if (outputBusy !== 1'b0 || outputS !== 1'b0) begin
      failures++; $display("FAIL home_pre_idle: busy %b S %b want 0 0", outputBusy, outputS);
    end
    n = 0;
    do begin tick(2'b10, 0); n++; end while (outputPos !== 4'd3 && n < 80);
    tests++; if (outputPos !== 4'd3) begin failures++; $display("FAIL home_reach3: got %0d want 3", outputPos); end
    tick(2'b11, 0);
    tests++; if (outputPos !== 4'd3 || outputS !== 1'b0) begin
      failures++; $display("FAIL home_entry: pos %0d S %b want 3 0", outputPos, outputS);
    end
    for (int i = 1; i <= 16; i++) begin
      tick(2'b11, 0);
      if (i == 4) begin tests++; if (outputPos !== 4'd2) begin failures++; $display("FAIL home_c4: got %0d want 2", outputPos); end end
      if (i == 8) begin tests++; if (outputPos !== 4'd1) begin failures++; $display("FAIL home_c8: got %0d want 1", outputPos); end end
      if (i == 11) begin tests++; if (outputPos !== 4'd1 || outputS !== 1'b0) begin
        failures++; $display("FAIL home_c11: pos %0d S %b want 1 0", outputPos, outputS); end end
      if (i == 12) begin tests++; if (outputPos !== 4'd0 || outputS !== 1'b1) begin
        failures++; $display("FAIL home_c12: pos %0d S %b want 0 1", outputPos, outputS); end end
      if (i == 16) begin tests++; if (outputPos !== 4'd0 || outputS !== 1'b1) begin
        failures++; $display("FAIL home_hold: pos %0d S %b want 0 1", outputPos, outputS); end end
    end
    tick(2'b00, 0);
    tests++; if (outputS !== 1'b0 || outputBusy !== 1'b0) begin
      failures++; $display("FAIL home_release: S %b busy %b want 0 0", outputS, outputBusy);
    end
  endtask

  task automatic test_request();
    tick(2'b00, 1);
    tests++; if (outputI !== 1'b0) begin failures++; $display("FAIL req_c1: got %b want 0", outputI); end
    tick(2'b00, 1);
    tests++; if (outputI !== 1'b0) begin failures++; $display("FAIL req_c2: got %b want 0", outputI); end
    tick(2'b00, 1);
    tests++; if (outputI !== 1'b1) begin failures++; $display("FAIL req_c3: got %b want 1", outputI); end
    tick(2'b01, 1);
    tests++; if (outputI !== 1'b0) begin failures++; $display("FAIL req_clear: got %b want 0", outputI); end
    for (int i = 0; i < 3; i++) tick(2'b00, 0);
    tick(2'b00, 1);
    tick(2'b00, 1);
    tests++; if (outputI !== 1'b0) begin failures++; $display("FAIL req_pre_both: got %b want 0", outputI); end
    tick(2'b01, 1);
    tests++; if (outputI !== 1'b1) begin failures++; $display("FAIL req_set_wins: got %b want 1", outputI); end
    tick(2'b00, 0);
  endtask

  task automatic test_reversal();
    int n;
    doReset();
    tick(2'b01, 0);
    n = 0;
    do begin tick(2'b01, 0); n++; end while (outputPos !== 4'd5 && n < 60);
    tests++; if (outputPos !== 4'd5) begin failures++; $display("FAIL rev_reach5: got %0d want 5", outputPos); end
    tick(2'b10, 0);
    tests++; if (outputPos !== 4'd5 || outputBusy !== 1'b1 || outputS !== 1'b0) begin
      failures++; $display("FAIL rev_edge: pos %0d busy %b S %b want 5 1 0", outputPos, outputBusy, outputS);
    end
    for (int i = 1; i <= LAG + 4; i++) begin
      tick(2'b10, 0);
      if (i < LAG + 4) begin
        tests++; if (outputPos !== 4'd5 || outputBusy !== 1'b1) begin
          failures++; $display("FAIL rev_wait_c%0d: pos %0d busy %b want 5 1", i, outputPos, outputBusy);
        end
      end else begin
        tests++; if (outputPos !== 4'd4) begin failures++; $display("FAIL rev_first_dec: got %0d want 4", outputPos); end
      end
    end
    tick(2'b00, 0);
  endtask

  task automatic test_reset_mid_move();
    int n;
    doReset();
    tick(2'b01, 0);
    n = 0;
    do begin tick(2'b01, 0); n++; end while (outputPos !== 4'd6 && n < 60);
    tick(2'b01, 0);
    tick(2'b01, 0);
    tests++; if (outputPos !== 4'd6 || outputBusy !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre: pos %0d busy %b want 6 1", outputPos, outputBusy);
    end
    inputReset = 1'b1;
    inputB1 = 1'b0; inputB0 = 1'b0;
    #1;
    tests++; if (outputPos !== 4'd0 || outputBusy !== 1'b0 || outputS !== 1'b0 || outputI !== 1'b0) begin
      failures++; $display("FAIL rst_mid_async: pos %0d busy %b S %b I %b want all 0", outputPos, outputBusy, outputS, outputI);
    end
    modelReset();
    @(negedge inputClk);
    @(negedge inputClk);
    inputReset = 1'b0;
    for (int i = 0; i < 8; i++) tick(2'b00, 0);
    tests++; if (outputPos !== 4'd0 || outputBusy !== 1'b0) begin
      failures++; $display("FAIL rst_mid_idle: pos %0d busy %b want 0 0", outputPos, outputBusy);
    end
  endtask

  task automatic test_down_at_zero();
    doReset();
    tick(2'b10, 0);
    tests++; if (outputS !== 1'b1 || outputBusy !== 1'b1 || outputPos !== 4'd0) begin
      failures++; $display("FAIL zero_entry: S %b busy %b pos %0d want 1 1 0", outputS, outputBusy, outputPos);
    end
    for (int i = 1; i <= 6; i++) begin
      tick(2'b10, 0);
      if (i == 4) begin tests++; if (outputPos !== 4'd0 || outputS !== 1'b1) begin
        failures++; $display("FAIL zero_step: pos %0d S %b want 0 1", outputPos, outputS); end end
    end
    tick(2'b00, 0);
  endtask

  task automatic test_random();
    logic [1:0] c;
    bit q;
    int hold;
    doReset();
    q = 0; c = 2'b00; hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        c = 2'($urandom_range(0, 3));
        hold = $urandom_range(1, 14);
      end
      hold--;
      if ($urandom_range(0, 4) == 0) q = !q;
      tick(c, q);
      tests++; if (outputPos !== 4'(mPos)) begin failures++; $display("FAIL rnd_pos@%0d: got %0d want %0d", i, outputPos, mPos); end
      tests++; if (outputS !== expS()) begin failures++; $display("FAIL rnd_S@%0d: got %b want %b", i, outputS, expS()); end
      tests++; if (outputBusy !== (mState != 0)) begin failures++; $display("FAIL rnd_busy@%0d: got %b want %b", i, outputBusy, mState != 0); end
      tests++; if (outputI !== mI) begin failures++; $display("FAIL rnd_I@%0d: got %b want %b", i, outputI, mI); end
    end
  endtask

  initial begin
    test_reset();
    test_up_to_limit();
    test_homing();
    test_request();
    test_reversal();
    test_reset_mid_move();
    test_down_at_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
